bitty_exec_ctrl: RTL

- Multi-cycle execute controller feeding the BittyPro 16-bit combinational ALU.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake and reads operands from an internal 8x16 register file.
- Drives the ALU operand, select, mode and carry_in inputs from registered values.
- Captures the ALU result, carry and compare outputs, then writes the result back to the register file.

---
 rtl/bitty_pkg.sv | 35 +++
 rtl/bitty_regfile.sv | 48 ++++
 rtl/bitty_exec_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/bitty_pkg.sv
// Shared definitions for the BittyPro execute controller: instruction formats,
// FSM encoding and instruction field positions.
package bitty_pkg;

  localparam int DATA_W   = 16;
  localparam int NUM_REGS = 8;
  localparam int REG_AW   = 3;

  localparam logic [1:0] FMT_ALU = 2'b00;
  localparam logic [1:0] FMT_LDI = 2'b01;
  localparam logic [1:0] FMT_CMP = 2'b10;
  localparam logic [1:0] FMT_NOP = 2'b11;

  localparam int RX_LSB   = 13;
  localparam int RY_LSB   = 10;
  localparam int MODE_BIT = 9;
  localparam int SEL_LSB  = 5;
  localparam int IMM_LSB  = 5;
  localparam int IMM_W    = 8;
  localparam int CIN_BIT  = 4;
  localparam int RSV_LSB  = 2;
  localparam int FMT_LSB  = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2,
    ST_WB     = 2'd3
  } state_e;

  function automatic logic fmt_uses_alu(input logic [1:0] fmt);
    return (fmt == FMT_ALU) || (fmt == FMT_CMP);
  endfunction

endpackage

// File: rtl/bitty_regfile.sv
// 8x16 register file: two capture-on-enable read ports, one combinational debug
// port, one write port. Capture takes one edge; never stalls; async clear.
module bitty_regfile
  import bitty_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [REG_AW-1:0] rd_addr_a,
  input  logic [REG_AW-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  input  logic              wr_en,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [REG_AW-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [DATA_W-1:0]               rd_a_q, rd_a_d;
  logic [DATA_W-1:0]               rd_b_q, rd_b_d;

  always_comb begin
    regs_d = regs_q;
    if (wr_en) regs_d[wr_addr] = wr_data;
    // Captured operands hold so the ALU inputs stay put outside EXEC.
    rd_a_d = rd_en ? regs_q[rd_addr_a] : rd_a_q;
    rd_b_d = rd_en ? regs_q[rd_addr_b] : rd_b_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '0;
      rd_a_q <= '0;
      rd_b_q <= '0;
    end else begin
      regs_q <= regs_d;
      rd_a_q <= rd_a_d;
      rd_b_q <= rd_b_d;
    end
  end

  assign rd_data_a = rd_a_q;
  assign rd_data_b = rd_b_q;
  assign dbg_data  = regs_q[dbg_addr];

endmodule

// File: rtl/bitty_exec_ctrl.sv
// Execute controller for the BittyPro ALU: done 3 edges after accept (ALU/CMP) or 2 (LDI/NOP);
// one instruction in flight, instr_ready low while busy. BITTY_EXEC_CARRY_CHAIN_EN gates cin with carry_flag.
module bitty_exec_ctrl
  import bitty_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic [DATA_W-1:0] alu_in_a,
  output logic [DATA_W-1:0] alu_in_b,
  output logic [3:0]        alu_select,
  output logic              alu_mode,
  output logic              alu_carry_in,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_carry_out,
  input  logic              alu_compare,
  output logic              done,
  output logic              busy,
  output logic              carry_flag,
  output logic              cmp_flag,
  input  logic [REG_AW-1:0] dbg_rd_addr,
  output logic [DATA_W-1:0] dbg_rd_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [3:0]        sel_q, sel_d;
  logic              mode_q, mode_d;
  logic              cin_q, cin_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              res_carry_q, res_carry_d;
  logic              res_cmp_q, res_cmp_d;
  logic              carry_flag_q, carry_flag_d;
  logic              cmp_flag_q, cmp_flag_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              instr_ready_q, instr_ready_d;

  logic [1:0]        fmt;
  logic              rf_rd_en;
  logic              rf_wr_en;
  logic [DATA_W-1:0] rf_wr_data;
  logic              unused_rsvd;

  assign fmt         = instr_q[FMT_LSB +: 2];
  assign unused_rsvd = ^instr_q[RSV_LSB +: 2];

  always_comb begin
    state_d      = state_q;
    instr_d      = instr_q;
    sel_d        = sel_q;
    mode_d       = mode_q;
    cin_d        = cin_q;
    res_d        = res_q;
    res_carry_d  = res_carry_q;
    res_cmp_d    = res_cmp_q;
    carry_flag_d = carry_flag_q;
    cmp_flag_d   = cmp_flag_q;
    rf_rd_en     = 1'b0;
    rf_wr_en     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          instr_d = instr;
          state_d = ST_DECODE;
        end
      end
      ST_DECODE: begin
        if (fmt_uses_alu(fmt)) begin
          rf_rd_en = 1'b1;
          sel_d    = instr_q[SEL_LSB +: 4];
          mode_d   = instr_q[MODE_BIT];
`ifdef BITTY_EXEC_CARRY_CHAIN_EN
          cin_d    = instr_q[CIN_BIT] & carry_flag_q;
`else
          cin_d    = instr_q[CIN_BIT];
`endif
          state_d  = ST_EXEC;
        end else begin
          state_d  = ST_WB;
        end
      end
      ST_EXEC: begin
        res_d       = alu_result;
        res_carry_d = alu_carry_out;
        res_cmp_d   = alu_compare;
        state_d     = ST_WB;
      end
      ST_WB: begin
        case (fmt)
          FMT_ALU: begin
            rf_wr_en     = 1'b1;
            carry_flag_d = res_carry_q;
            cmp_flag_d   = res_cmp_q;
          end
          FMT_CMP: begin
            carry_flag_d = res_carry_q;
            cmp_flag_d   = res_cmp_q;
          end
          FMT_LDI: rf_wr_en = 1'b1;
          default: ;
        endcase
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Status outputs are registered from the next state so they line up with it.
    done_d        = (state_d == ST_WB);
    busy_d        = (state_d != ST_IDLE);
    instr_ready_d = (state_d == ST_IDLE);
  end

  assign rf_wr_data = (fmt == FMT_LDI) ?
                      {{(DATA_W-IMM_W){1'b0}}, instr_q[IMM_LSB +: IMM_W]} : res_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      instr_q       <= '0;
      sel_q         <= '0;
      mode_q        <= 1'b0;
      cin_q         <= 1'b0;
      res_q         <= '0;
      res_carry_q   <= 1'b0;
      res_cmp_q     <= 1'b0;
      carry_flag_q  <= 1'b0;
      cmp_flag_q    <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b0;
      instr_ready_q <= 1'b1;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      sel_q         <= sel_d;
      mode_q        <= mode_d;
      cin_q         <= cin_d;
      res_q         <= res_d;
      res_carry_q   <= res_carry_d;
      res_cmp_q     <= res_cmp_d;
      carry_flag_q  <= carry_flag_d;
      cmp_flag_q    <= cmp_flag_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      instr_ready_q <= instr_ready_d;
    end
  end

  bitty_regfile u_regfile (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_en     (rf_rd_en),
    .rd_addr_a (instr_q[RX_LSB +: REG_AW]),
    .rd_addr_b (instr_q[RY_LSB +: REG_AW]),
    .rd_data_a (alu_in_a),
    .rd_data_b (alu_in_b),
    .wr_en     (rf_wr_en),
    .wr_addr   (instr_q[RX_LSB +: REG_AW]),
    .wr_data   (rf_wr_data),
    .dbg_addr  (dbg_rd_addr),
    .dbg_data  (dbg_rd_data)
  );

  assign alu_select   = sel_q;
  assign alu_mode     = mode_q;
  assign alu_carry_in = cin_q;
  assign done         = done_q;
  assign busy         = busy_q;
  assign instr_ready  = instr_ready_q;
  assign carry_flag   = carry_flag_q;
  assign cmp_flag     = cmp_flag_q;

endmodule
